// File: rtl/nonce_search_ctrl_if.sv
// Hash-core handshake bundle for nonce_search_ctrl.
// The controller (master) sends the start pulse and block; the core (slave) returns the result and ready.
interface nonce_search_ctrl_if #(
    parameter int NONCE_W = 32,
    parameter int BLOCK_W = 96,
    parameter int HASH_W  = 24
);
    logic                       hash_start;
    logic [NONCE_W+BLOCK_W-1:0] hash_block;
    logic [HASH_W-1:0]          hash_in;
    logic                       hash_ready;

    modport master (output hash_start, hash_block, input hash_in, hash_ready);
    modport slave  (input hash_start, hash_block, output hash_in, hash_ready);
endinterface

// File: rtl/nonce_search_ctrl.sv
// Nonce-search controller: sweeps [nonce_start, nonce_limit] by nonce_step through an external hash core.
// Optional NONCE_SEARCH_STATS_EN adds the 32-bit saturating 'attempts' counter port.
module nonce_search_ctrl #(
    parameter int NONCE_W       = 32,
    parameter int BLOCK_W       = 96,
    parameter int HASH_W        = 24,
    parameter int CMP_BYTES     = 2,
    parameter bit BYTE_SWAP_OUT = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          target,
    input  logic [BLOCK_W-1:0]  block,
    input  logic [NONCE_W-1:0]  nonce_start,
    input  logic [NONCE_W-1:0]  nonce_limit,
    input  logic [NONCE_W-1:0]  nonce_step,
    nonce_search_ctrl_if.master core,
    output logic                busy,
    output logic                found,
    output logic                exhausted,
    output logic [NONCE_W-1:0]  nonce_out,
`ifdef NONCE_SEARCH_STATS_EN
    output logic [31:0]         attempts,
`endif
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [NONCE_W-1:0] STEP_ONE = NONCE_W'(1);

    state_t                     state_q, state_d;
    logic [7:0]                 target_r;
    logic [BLOCK_W-1:0]         block_r;
    logic [NONCE_W-1:0]         limit_r, step_r, nonce_cur;
    logic [HASH_W-1:0]          hash_r;
    logic [NONCE_W+BLOCK_W-1:0] hash_block_r;
    logic                       hash_start_r;
    logic                       take_result, hit, last_nonce;
    logic [NONCE_W-1:0]         nonce_swapped;
    logic                       unused_hash_bits;

    // A ready coinciding with our own start pulse belongs to no request of this run.
    assign take_result = (state_q == ST_WAIT) && core.hash_ready && !hash_start_r;
    assign last_nonce  = (nonce_cur > limit_r) || ((limit_r - nonce_cur) < step_r);

    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        hit = 1'b1;
        for (int k = 0; k < CMP_BYTES; k++) begin
            if (hash_r[HASH_W-1-8*k -: 8] > target_r) hit = 1'b0;
        end
    end

    always_comb begin
        nonce_swapped = '0;
        for (int b = 0; b < NONCE_W/8; b++) begin
            nonce_swapped[8*b +: 8] = nonce_cur[NONCE_W-1-8*b -: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (take_result) state_d = ST_CHECK;
            ST_CHECK: state_d = (hit || last_nonce) ? ST_DONE : ST_ISSUE;
            ST_DONE:  if (!start) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    // NOTE: sequential state is assigned with non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target_r     <= '0;
            block_r      <= '0;
            limit_r      <= '0;
            step_r       <= '0;
            nonce_cur    <= '0;
            hash_r       <= '0;
            hash_block_r <= '0;
            hash_start_r <= 1'b0;
            found        <= 1'b0;
            exhausted    <= 1'b0;
            nonce_out    <= '0;
`ifdef NONCE_SEARCH_STATS_EN
            attempts     <= '0;
`endif
        end else begin
            hash_start_r <= (state_q == ST_ISSUE) && !abort;
            if (abort) begin
                found     <= 1'b0;
                exhausted <= 1'b0;
`ifdef NONCE_SEARCH_STATS_EN
                attempts  <= '0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        target_r  <= target;
                        block_r   <= block;
                        limit_r   <= nonce_limit;
                        step_r    <= (nonce_step == '0) ? STEP_ONE : nonce_step;
                        nonce_cur <= nonce_start;
                        if (start) begin
                            found     <= 1'b0;
                            exhausted <= 1'b0;
`ifdef NONCE_SEARCH_STATS_EN
                            attempts  <= '0;
`endif
                        end
                    end
                    ST_ISSUE: hash_block_r <= {nonce_cur, block_r};
                    ST_WAIT:  if (take_result) hash_r <= core.hash_in;
                    ST_CHECK: begin
`ifdef NONCE_SEARCH_STATS_EN
                        if (attempts != 32'hFFFF_FFFF) attempts <= attempts + 32'd1;
`endif
                        if (hit) begin
                            found     <= 1'b1;
                            nonce_out <= BYTE_SWAP_OUT ? nonce_swapped : nonce_cur;
                        end else if (last_nonce) begin
                            exhausted <= 1'b1;
                        end else begin
                            nonce_cur <= nonce_cur + step_r;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy             = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign state            = state_q;
    assign core.hash_start  = hash_start_r && !abort;
    assign core.hash_block  = hash_block_r;
    // Hash bytes below the compared window are captured but never looked at.
    assign unused_hash_bits = ^hash_r;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Self-checking bench for nonce_search_ctrl: directed and randomized searches against a range-walk model,
// with a behavioural hash core of random latency. Build with +define+NONCE_SEARCH_STATS_EN to cover 'attempts'.
module tb_nonce_search_ctrl;

    logic        clk, reset, start, abort;
    logic [7:0]  target;
    logic [95:0] block;
    logic [31:0] nonce_start, nonce_limit, nonce_step;
    logic        busy, found, exhausted;
    logic [31:0] nonce_out;
    logic [2:0]  state;
`ifdef NONCE_SEARCH_STATS_EN
    logic [31:0] attempts;
`endif

    int tests  = 0;
    int failed = 0;

    nonce_search_ctrl_if #(.NONCE_W(32), .BLOCK_W(96), .HASH_W(24)) bus ();

    nonce_search_ctrl #(
        .NONCE_W(32), .BLOCK_W(96), .HASH_W(24), .CMP_BYTES(2), .BYTE_SWAP_OUT(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .target(target), .block(block),
        .nonce_start(nonce_start), .nonce_limit(nonce_limit), .nonce_step(nonce_step),
        .core(bus.master), .busy(busy), .found(found), .exhausted(exhausted), .nonce_out(nonce_out),
`ifdef NONCE_SEARCH_STATS_EN
        .attempts(attempts),
`endif
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural hash core ----------------
    int          hmode = 0;
    logic [31:0] hit_nonce = '0;
    logic [23:0] hit_val = '0;
    logic [31:0] hseed = '0;
    bit          core_auto = 1'b1;
    logic [31:0] issued[$];
    logic [127:0] last_hb = '0;
    logic        auto_ready = 1'b0, man_ready = 1'b0;
    logic [23:0] auto_hash = '0, man_hash = '0;
    int          cnt = 0;
    logic [31:0] pend = '0;

    assign bus.hash_ready = auto_ready | man_ready;
    assign bus.hash_in    = man_ready ? man_hash : auto_hash;

    function automatic logic [23:0] hash_of(input logic [31:0] n);
        logic [31:0] m;
        case (hmode)
            1: return (n == hit_nonce) ? hit_val : 24'hFFFFFF;
            2: begin m = (n * 32'h9E37_79B1) ^ hseed; return m[31:8]; end
            default: return 24'hFFFFFF;
        endcase
    endfunction

    function automatic bit is_hit(input logic [23:0] h, input logic [7:0] t);
        return (h[23:16] <= t) && (h[15:8] <= t);
    endfunction

    always @(negedge clk) begin
        auto_ready = 1'b0;
        if (reset) cnt = 0;
        else begin
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    auto_ready = 1'b1;
                    auto_hash  = hash_of(pend);
                end
            end
            if (bus.hash_start === 1'b1) begin
                issued.push_back(bus.hash_block[127:96]);
                last_hb = bus.hash_block;
                pend    = bus.hash_block[127:96];
                if (core_auto) cnt = $urandom_range(1, 4);
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " reaches state"}, state, s);
    endtask

    logic [31:0] nout_model = '0;

    // One complete search: model the expected nonce walk, run the DUT, compare.
    task automatic run_search(input string tag, input logic [31:0] s, input logic [31:0] l,
                              input logic [31:0] st, input logic [7:0] t);
        logic [31:0] exp_q[$];
        logic [31:0] tmp;
        logic [95:0] blk;
        bit          exp_found = 1'b0, exp_exh = 1'b0;
        longint      n, lim, eff;
        int          lat;

        n   = s;
        lim = l;
        eff = (st == 0) ? 1 : st;
        forever begin
            tmp = n[31:0];
            exp_q.push_back(tmp);
            if (is_hit(hash_of(tmp), t)) begin exp_found = 1'b1; break; end
            if (n > lim || n + eff > lim) begin exp_exh = 1'b1; break; end
            n += eff;
            if (exp_q.size() >= 64) break;
        end
        if (exp_found) begin
            tmp = exp_q[exp_q.size()-1];
            nout_model = {<<8{tmp}};
        end

        blk = {$urandom, $urandom, $urandom};
        @(negedge clk);
        nonce_start = s; nonce_limit = l; nonce_step = st; target = t; block = blk;
        start = 1'b1;
        issued.delete();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.hash_start !== 1'b1 && lat < 10);
        check({tag, " start-to-hash_start"}, lat, 2);
        check({tag, " busy while running"}, busy, 1'b1);
        // Inputs must be ignored for the rest of the run.
        target = $urandom; block = {$urandom, $urandom, $urandom};
        nonce_start = $urandom; nonce_limit = $urandom; nonce_step = $urandom;

        wait_state(3'd4, 3000, tag);
        check({tag, " found"}, found, exp_found);
        check({tag, " exhausted"}, exhausted, exp_exh);
        check({tag, " busy in DONE"}, busy, 1'b0);
        check({tag, " hash_start count"}, issued.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < issued.size(); i++)
            check($sformatf("%s nonce[%0d]", tag, i), issued[i], exp_q[i]);
        check({tag, " hash_block payload"}, last_hb[95:0], blk);
        check({tag, " nonce_out"}, nonce_out, nout_model);
`ifdef NONCE_SEARCH_STATS_EN
        check({tag, " attempts"}, attempts, exp_q.size());
`endif
        repeat (2) @(negedge clk);
        check({tag, " DONE holds while start"}, state, 3'd4);
        check({tag, " found held in DONE"}, found, exp_found);
        start = 1'b0;
        @(negedge clk);
        check({tag, " back to IDLE"}, state, 3'd0);
        check({tag, " found held in IDLE"}, found, exp_found);
        check({tag, " exhausted held in IDLE"}, exhausted, exp_exh);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] s, l, st;
        int          len, n;

        reset = 1'b1; start = 1'b0; abort = 1'b0; target = '0; block = '0;
        nonce_start = '0; nonce_limit = '0; nonce_step = '0;
        repeat (3) @(negedge clk);
        check("reset state", state, 3'd0);
        check("reset busy", busy, 1'b0);
        check("reset found", found, 1'b0);
        check("reset exhausted", exhausted, 1'b0);
        check("reset nonce_out", nonce_out, 32'h0);
        check("reset hash_start", bus.hash_start, 1'b0);
        check("reset hash_block", bus.hash_block, 128'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle after reset", state, 3'd0);

        // Basic hit on nonce 5.
        hmode = 1; hit_nonce = 32'd5; hit_val = 24'h0A0BFF; core_auto = 1'b1;
        run_search("basic", 32'h0, 32'hFFFF_FFFF, 32'd1, 8'h10);
        check("basic nonce_out literal", nonce_out, 32'h0500_0000);

        hmode = 0;
        run_search("exhaust", 32'h10, 32'h13, 32'd1, 8'h10);

        hmode = 1; hit_nonce = 32'd9; hit_val = 24'h0000FF;
        run_search("step4", 32'd1, 32'd9, 32'd4, 8'h10);

        hmode = 0;
        run_search("step0", 32'd7, 32'd8, 32'd0, 8'h10);
        run_search("reverse", 32'h20, 32'h10, 32'd1, 8'h10);
        run_search("single", 32'h0, 32'h0, 32'd1, 8'h10);

        // Abort in WAIT with a simultaneous (hitting) ready; ready during hash_start is ignored.
        core_auto = 1'b0;
        @(negedge clk);
        nonce_start = 32'h100; nonce_limit = 32'h1FF; nonce_step = 32'd1; target = 8'hFF; start = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.hash_start !== 1'b1 && n < 10);
        check("abort run hash_start seen", bus.hash_start, 1'b1);
        man_hash = 24'hFFFFFF; man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        check("ready with hash_start ignored", state, 3'd2);
        @(negedge clk);
        abort = 1'b1; start = 1'b0; man_hash = 24'h000000; man_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; man_ready = 1'b0;
        check("abort -> IDLE", state, 3'd0);
        check("abort found", found, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort exhausted", exhausted, 1'b0);
        check("abort keeps nonce_out", nonce_out, nout_model);
        repeat (2) @(negedge clk);
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stale ready state %0d", i), state, 3'd0);
            check($sformatf("stale ready hash_start %0d", i), bus.hash_start, 1'b0);
            @(negedge clk);
        end

        // Abort in the cycle the start pulse is out: pulse must be suppressed at once.
        start = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.hash_start !== 1'b1 && n < 10);
        abort = 1'b1; start = 1'b0;
        #1;
        check("abort masks hash_start", bus.hash_start, 1'b0);
        @(negedge clk);
        abort = 1'b0;
        check("abort2 -> IDLE", state, 3'd0);

        // Reset mid-run also clears nonce_out.
        start = 1'b1;
        wait_state(3'd2, 20, "midrun");
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        nout_model = '0;
        check("midrun reset state", state, 3'd0);
        check("midrun reset nonce_out", nonce_out, 32'h0);
        check("midrun reset busy", busy, 1'b0);
        check("midrun reset hash_block", bus.hash_block, 128'h0);

        // Randomized ranges, steps, targets and core latency.
        core_auto = 1'b1;
        for (int r = 0; r < 8; r++) begin
            hmode = 2; hseed = $urandom;
            s   = $urandom_range(32'h100, 32'h7FFF_FFFF);
            len = $urandom_range(0, 10);
            st  = $urandom_range(0, 4);
            l   = (r % 4 == 3) ? s - 32'(len) - 32'd1 : s + 32'(len);
            run_search($sformatf("rand%0d", r), s, l, st, 8'($urandom_range(8'h30, 8'hA0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/nonce_search_ctrl.md
Name: nonce_search_ctrl

Overview:
- Parametrised nonce-search controller for the mining datapath.
- Drives an external hash core (micro_ucr_hash or a wider successor) through a start/ready handshake.
- Sweeps a programmable nonce range [nonce_start, nonce_limit] with a programmable step, so several instances can split the nonce space.
- Compares the top CMP_BYTES hash bytes against a target; reports the found nonce, or range exhaustion.

Parameters:
- NONCE_W, 32: nonce width in bits; multiple of 8.
- BLOCK_W, 96: width of the fixed block payload.
- HASH_W, 24: hash core output width; multiple of 8.
- CMP_BYTES, 2: number of most-significant hash bytes compared to the target; 1..HASH_W/8.
- BYTE_SWAP_OUT, 1: 1 = nonce_out is byte-reversed relative to the internal nonce; 0 = unchanged.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level request; sampled in IDLE only.
- abort  in  1  one-cycle cancel; effective from any state.
- target  in  8  per-byte threshold.
- block  in  BLOCK_W  payload.
- nonce_start  in  NONCE_W  first nonce.
- nonce_limit  in  NONCE_W  last nonce allowed (inclusive).
- nonce_step  in  NONCE_W  increment; 0 is treated as 1.
- hash_start  out  1  one-cycle pulse to the hash core.
- hash_block  out  NONCE_W+BLOCK_W  core input = {nonce_cur, block_r}.
- hash_in  in  HASH_W  core result.
- hash_ready  in  1  core result valid.
- busy  out  1  search in progress.
- found  out  1  valid nonce found.
- exhausted  out  1  range finished with no hit.
- nonce_out  out  NONCE_W  winning nonce.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset:
  - state=IDLE; busy, found, exhausted, hash_start = 0.
  - nonce_out, hash_block and all internal registers = 0.
- FSM states: IDLE=0, ISSUE=1, WAIT=2, CHECK=3, DONE=4. Any other encoding goes to IDLE on the next clock.
- IDLE:
  - Every cycle, registers target_r<=target, block_r<=block, limit_r, step_r (0->1), nonce_cur<=nonce_start.
  - start=1 -> ISSUE next cycle; busy=1; found/exhausted cleared.
  - target, block, range and step are frozen for the whole run.
- ISSUE:
  - hash_start=1 for exactly one cycle; hash_block={nonce_cur, block_r}, held stable until the next ISSUE.
  - -> WAIT.
- WAIT:
  - Stay in WAIT until hash_ready=1.
  - On hash_ready=1, capture hash_in into hash_r and go to CHECK.
  - hash_ready asserted in the same cycle as hash_start is ignored.
  - Any hash_ready pulse arriving outside WAIT is ignored.
- CHECK: hit = every byte hash_r[HASH_W-1-8k -: 8] <= target_r, for k = 0..CMP_BYTES-1 (unsigned compare).
  - hit -> DONE; found=1; nonce_out = nonce_cur (byte-reversed if BYTE_SWAP_OUT).
  - else if (limit_r - nonce_cur) < step_r (unsigned, NONCE_W bits) -> DONE; exhausted=1.
  - else nonce_cur <= nonce_cur + step_r -> ISSUE. No wrap-around is possible, because of the limit check.
  - nonce_start > nonce_limit: the first nonce is still hashed, then the range is exhausted (unless it hits).
- Latency:
  - start to first hash_start: 2 cycles.
  - Per-nonce overhead beyond core latency: 3 cycles (ISSUE, CHECK, plus the WAIT capture edge).
- DONE:
  - busy=0; found/exhausted/nonce_out hold.
  - -> IDLE when start=0. found/exhausted stay set until the next start.
- abort:
  - Any state -> IDLE next cycle; busy/found/exhausted = 0; hash_start forced 0 in that cycle.
  - abort has priority over start and over a simultaneous hash_ready.
  - A later stale hash_ready from the core is ignored, because the FSM is not in WAIT.
- reset mid-run: identical to abort, and also clears nonce_out.

Optional Feature:
- Macro NONCE_SEARCH_STATS_EN.
- When defined:
  - Adds output port attempts (32 bits): number of completed CHECK evaluations in the current run.
  - Cleared on the IDLE->ISSUE transition; saturates at 0xFFFFFFFF; holds in DONE.
  - Cleared on reset and abort.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic hit: nonce_start=0, step=1, limit=0xFFFFFFFF, target=0x10. Core model returns 0xFFFFFF for nonces 0..4 and 0x0A0BFF for nonce 5 -> found=1, exhausted=0, nonce_out=0x05000000 (BYTE_SWAP_OUT=1), 6 hash_start pulses.
- Exhaustion: start=0x10, limit=0x13, step=1, core always 0xFFFFFF -> nonces 0x10..0x13 hashed, exhausted=1, found=0, busy=0.
- Step split: start=1, step=4, limit=9, core hits only on nonce 9 -> hash_block nonces 1,5,9, then found=1. step=0 with start=7, limit=8 -> nonces 7,8 hashed (step treated as 1).
- Reverse range: start=0x20, limit=0x10, miss -> one hash_start, then exhausted=1.
- Abort: abort in WAIT with hash_ready in the same cycle -> IDLE, found=0. A second hash_ready 3 cycles later -> no state change, no hash_start.
- Stats (NONCE_SEARCH_STATS_EN): the basic-hit case gives attempts=6. A restart with a miss on start=limit=0 gives attempts=1.
